// File: rtl/alu_run_ctrl_if.sv
// Signal bundle for alu_run_ctrl: power/load command, operand stream and status.
// The controller connects through the slave modport; whoever drives it uses the master modport.
interface alu_run_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             on;
   logic             load;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [CNT_W-1:0] len;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic [WIDTH-1:0] acc;
   logic [1:0]       state;
   logic             done;
   logic             error;

   modport master (
      output on, load, op, a, len, in_valid, in_data,
      input  in_ready, acc, state, done, error
   );

   modport slave (
      input  on, load, op, a, len, in_valid, in_data,
      output in_ready, acc, state, done, error
   );
endinterface

// File: rtl/alu_run_ctrl.sv
// Multi-beat accumulate run controller (OFF/READY/RUN/ERROR) for the ALU datapath.
// Define ALU_RUN_SAT_EN to saturate on overflow instead of diverting to ERROR.
module alu_run_ctrl #(
   parameter int WIDTH    = 8,
   parameter int CNT_W    = 4,
   parameter int ERR_HOLD = 3
) (
   input logic           clk,
   input logic           rst,
   alu_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_READY = 2'b01,
      ST_RUN   = 2'b10,
      ST_ERROR = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } op_e;

   state_e           state_q;
   state_e           state_d;
   op_e              op_q;
   logic [WIDTH-1:0] acc_q;
   logic [CNT_W-1:0] rem_q;
   logic             done_q;

   logic             start;
   logic             beat;
   logic             last_beat;
   logic             ovf;
   logic             abort;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] acc_nxt;

   // Power-down has priority: a load only starts while on is still held.
   assign start     = (state_q == ST_READY) && bus.on && bus.load;
   assign beat      = (state_q == ST_RUN) && bus.in_valid;
   assign last_beat = (rem_q == CNT_W'(1));

   // One-bit-wider add/subtract exposes carry-out and borrow in the MSB.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      sum     = {1'b0, acc_q} + {1'b0, bus.in_data};
      diff    = {1'b0, acc_q} - {1'b0, bus.in_data};
      alu_res = sum[WIDTH-1:0];
      ovf     = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            ovf     = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            ovf     = diff[WIDTH];
         end
         OP_AND: alu_res = acc_q & bus.in_data;
         OP_XOR: alu_res = acc_q ^ bus.in_data;
      endcase
   end

`ifdef ALU_RUN_SAT_EN
   assign abort = 1'b0;

   always_comb begin
      acc_nxt = alu_res;
      if (ovf) begin
         acc_nxt = (op_q == OP_ADD) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
      end
   end
`else
   localparam int ERR_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD) : 1;

   logic [ERR_W-1:0] err_cnt_q;

   assign abort   = ovf;
   assign acc_nxt = alu_res;

   // Loaded with ERR_HOLD-1 on entry so ERROR lasts exactly ERR_HOLD cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (beat && abort) begin
         err_cnt_q <= ERR_W'(ERR_HOLD - 1);
      end else if ((state_q == ST_ERROR) && (err_cnt_q != '0)) begin
         err_cnt_q <= err_cnt_q - ERR_W'(1);
      end
   end
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q <= ST_READY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_OFF: begin
            if (bus.on) state_d = ST_READY;
         end
         ST_READY: begin
            if (!bus.on) begin
               state_d = ST_OFF;
            end else if (bus.load && (bus.len != '0)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (beat) begin
               if (abort) begin
                  state_d = ST_ERROR;
               end else if (last_beat) begin
                  state_d = ST_READY;
               end
            end
         end
         ST_ERROR: begin
`ifdef ALU_RUN_SAT_EN
            state_d = ST_READY;
`else
            if (err_cnt_q == '0) state_d = ST_READY;
`endif
         end
      endcase
   end

   // Datapath: op/acc/remaining are captured on load; an aborted beat leaves acc untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         rem_q  <= '0;
         op_q   <= OP_ADD;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            op_q   <= op_e'(bus.op);
            acc_q  <= bus.a;
            rem_q  <= bus.len;
            done_q <= (bus.len == '0);
         end else if (beat) begin
            rem_q <= rem_q - CNT_W'(1);
            if (!abort) begin
               acc_q  <= acc_nxt;
               done_q <= last_beat;
            end
         end
      end
   end

   // Output decode
   always_comb begin
      bus.in_ready = (state_q == ST_RUN);
      bus.error    = (state_q == ST_ERROR);
      bus.state    = state_q;
      bus.acc      = acc_q;
      bus.done     = done_q;
   end

endmodule

// File: tb/tb_alu_run_ctrl.sv
// Directed self-checking bench for alu_run_ctrl (WIDTH=8, CNT_W=4, ERR_HOLD=3).
`timescale 1ns/1ps
module tb_alu_run_ctrl;

   localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, XOR = 2'b11;
   localparam logic [1:0] S_OFF = 2'b00, S_READY = 2'b01, S_RUN = 2'b10, S_ERR = 2'b11;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   alu_run_ctrl_if #(.WIDTH(8), .CNT_W(4)) bus ();

   alu_run_ctrl #(.WIDTH(8), .CNT_W(4), .ERR_HOLD(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [1:0] op, input logic [7:0] a, input logic [3:0] len);
      bus.op   = op;
      bus.a    = a;
      bus.len  = len;
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic beat(input logic [7:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (bus.state !== S_READY) begin failures++; $display("FAIL rst_state: got %b want %b", bus.state, S_READY); end
      checks++; if (bus.acc !== 8'h00) begin failures++; $display("FAIL rst_acc: got %h want 00", bus.acc); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", bus.done); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL rst_error: got %b want 0", bus.error); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      rst = 1'b0;
      tick();
      do_load(ADD, 8'h33, 4'd0);
      checks++; if (bus.acc !== 8'h33 || bus.done !== 1'b1) begin failures++; $display("FAIL rst_preload: acc=%h done=%b want 33/1", bus.acc, bus.done); end
      // Asynchronous reset: checked before any clock edge can occur.
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.acc !== 8'h00) begin failures++; $display("FAIL rst_async_acc: got %h want 00", bus.acc); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_async_done: got %b want 0", bus.done); end
      checks++; if (bus.state !== S_READY) begin failures++; $display("FAIL rst_async_state: got %b want 01", bus.state); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_normal_run();
      do_load(ADD, 8'h10, 4'd3);
      checks++; if (bus.state !== S_RUN || bus.acc !== 8'h10) begin failures++; $display("FAIL run_start: state=%b acc=%h want 10/10", bus.state, bus.acc); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL run_in_ready_idle: got %b want 1", bus.in_ready); end
      beat(8'h01);
      checks++; if (bus.acc !== 8'h11 || bus.done !== 1'b0) begin failures++; $display("FAIL run_beat1: acc=%h done=%b want 11/0", bus.acc, bus.done); end
      tick();
      beat(8'h02);
      checks++; if (bus.acc !== 8'h13 || bus.state !== S_RUN) begin failures++; $display("FAIL run_beat2: acc=%h state=%b want 13/10", bus.acc, bus.state); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL run_idle_done: got %b want 0", bus.done); end
      beat(8'h03);
      checks++; if (bus.acc !== 8'h16 || bus.done !== 1'b1 || bus.state !== S_READY) begin failures++; $display("FAIL run_final: acc=%h done=%b state=%b want 16/1/01", bus.acc, bus.done, bus.state); end
      tick();
      checks++; if (bus.done !== 1'b0 || bus.acc !== 8'h16) begin failures++; $display("FAIL run_done_pulse: done=%b acc=%h want 0/16", bus.done, bus.acc); end
   endtask

   task automatic test_ops();
      do_load(AND, 8'hF0, 4'd2);
      bus.op = XOR;  // live op must be ignored during the run
      beat(8'h3C);
      checks++; if (bus.acc !== 8'h30) begin failures++; $display("FAIL and_beat1: got %h want 30", bus.acc); end
      beat(8'h1F);
      checks++; if (bus.acc !== 8'h10 || bus.done !== 1'b1) begin failures++; $display("FAIL and_final: acc=%h done=%b want 10/1", bus.acc, bus.done); end
      do_load(XOR, 8'hA5, 4'd1);
      beat(8'hFF);
      checks++; if (bus.acc !== 8'h5A || bus.done !== 1'b1) begin failures++; $display("FAIL xor: acc=%h done=%b want 5A/1", bus.acc, bus.done); end
      do_load(SUB, 8'h10, 4'd2);
      beat(8'h03);
      checks++; if (bus.acc !== 8'h0D) begin failures++; $display("FAIL sub_beat1: got %h want 0D", bus.acc); end
      beat(8'h0D);
      checks++; if (bus.acc !== 8'h00 || bus.done !== 1'b1 || bus.error !== 1'b0) begin failures++; $display("FAIL sub_equal: acc=%h done=%b err=%b want 00/1/0", bus.acc, bus.done, bus.error); end
      do_load(ADD, 8'hFE, 4'd1);
      beat(8'h01);
      checks++; if (bus.acc !== 8'hFF || bus.state !== S_READY || bus.done !== 1'b1) begin failures++; $display("FAIL add_edge: acc=%h state=%b done=%b want FF/01/1", bus.acc, bus.state, bus.done); end
      tick();
   endtask

`ifdef ALU_RUN_SAT_EN
   task automatic test_overflow();
      do_load(ADD, 8'hF0, 4'd2);
      beat(8'h20);
      checks++; if (bus.acc !== 8'hFF || bus.state !== S_RUN || bus.error !== 1'b0) begin failures++; $display("FAIL sat_add: acc=%h state=%b err=%b want FF/10/0", bus.acc, bus.state, bus.error); end
      beat(8'h00);
      checks++; if (bus.acc !== 8'hFF || bus.done !== 1'b1 || bus.state !== S_READY) begin failures++; $display("FAIL sat_add_done: acc=%h done=%b state=%b want FF/1/01", bus.acc, bus.done, bus.state); end
      do_load(SUB, 8'h05, 4'd1);
      beat(8'h06);
      checks++; if (bus.acc !== 8'h00 || bus.done !== 1'b1 || bus.error !== 1'b0) begin failures++; $display("FAIL sat_sub: acc=%h done=%b err=%b want 00/1/0", bus.acc, bus.done, bus.error); end
      tick();
   endtask
`else
   task automatic wait_error(input string name, input logic [7:0] exp_acc);
      int err_cycles = 1;
      logic done_seen = 1'b0;
      bus.in_valid = 1'b1;  // beats offered during ERROR must be ignored
      bus.in_data  = 8'h01;
      for (int i = 0; i < 8 && bus.state == S_ERR; i++) begin
         tick();
         if (bus.state == S_ERR) err_cycles++;
         if (bus.done === 1'b1) done_seen = 1'b1;
      end
      bus.in_valid = 1'b0;
      checks++; if (err_cycles != 3) begin failures++; $display("FAIL %s_err_len: got %0d cycles want 3", name, err_cycles); end
      checks++; if (bus.state !== S_READY || bus.error !== 1'b0) begin failures++; $display("FAIL %s_exit: state=%b err=%b want 01/0", name, bus.state, bus.error); end
      checks++; if (done_seen !== 1'b0 || bus.acc !== exp_acc) begin failures++; $display("FAIL %s_no_done: done_seen=%b acc=%h want 0/%h", name, done_seen, bus.acc, exp_acc); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_late_done: got %b want 0", name, bus.done); end
   endtask

   task automatic test_overflow();
      do_load(ADD, 8'hF0, 4'd2);
      beat(8'h20);
      checks++; if (bus.state !== S_ERR || bus.error !== 1'b1) begin failures++; $display("FAIL ovf_add_entry: state=%b err=%b want 11/1", bus.state, bus.error); end
      checks++; if (bus.acc !== 8'hF0 || bus.in_ready !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL ovf_add_hold: acc=%h rdy=%b done=%b want F0/0/0", bus.acc, bus.in_ready, bus.done); end
      wait_error("ovf_add", 8'hF0);
      do_load(SUB, 8'h05, 4'd1);
      beat(8'h06);
      checks++; if (bus.state !== S_ERR || bus.acc !== 8'h05) begin failures++; $display("FAIL ovf_sub_entry: state=%b acc=%h want 11/05", bus.state, bus.acc); end
      wait_error("ovf_sub", 8'h05);
   endtask
`endif

   task automatic test_back_to_back();
      do_load(ADD, 8'h01, 4'd1);
      beat(8'h01);
      checks++; if (bus.done !== 1'b1 || bus.acc !== 8'h02) begin failures++; $display("FAIL b2b_first: done=%b acc=%h want 1/02", bus.done, bus.acc); end
      do_load(ADD, 8'h40, 4'd0);
      checks++; if (bus.done !== 1'b1 || bus.acc !== 8'h40 || bus.state !== S_READY) begin failures++; $display("FAIL b2b_reload: done=%b acc=%h state=%b want 1/40/01", bus.done, bus.acc, bus.state); end
      do_load(ADD, 8'h00, 4'd2);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h05;
      tick();
      checks++; if (bus.acc !== 8'h05 || bus.done !== 1'b0 || bus.state !== S_RUN) begin failures++; $display("FAIL b2b_held1: acc=%h done=%b state=%b want 05/0/10", bus.acc, bus.done, bus.state); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.acc !== 8'h0A || bus.done !== 1'b1 || bus.state !== S_READY) begin failures++; $display("FAIL b2b_held2: acc=%h done=%b state=%b want 0A/1/01", bus.acc, bus.done, bus.state); end
      tick();
   endtask

   task automatic test_power();
      do_load(ADD, 8'h12, 4'd0);
      tick();
      bus.on = 1'b0;
      do_load(ADD, 8'h77, 4'd0);
      checks++; if (bus.state !== S_OFF || bus.acc !== 8'h12 || bus.done !== 1'b0) begin failures++; $display("FAIL pwr_off_prio: state=%b acc=%h done=%b want 00/12/0", bus.state, bus.acc, bus.done); end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h01;
      do_load(ADD, 8'h55, 4'd0);
      bus.in_valid = 1'b0;
      checks++; if (bus.state !== S_OFF || bus.acc !== 8'h12 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL pwr_off_ignore: state=%b acc=%h rdy=%b want 00/12/0", bus.state, bus.acc, bus.in_ready); end
      bus.on = 1'b1;
      tick();
      checks++; if (bus.state !== S_READY) begin failures++; $display("FAIL pwr_on: got %b want 01", bus.state); end
      do_load(ADD, 8'h55, 4'd0);
      checks++; if (bus.acc !== 8'h55 || bus.done !== 1'b1 || bus.state !== S_READY) begin failures++; $display("FAIL pwr_len0: acc=%h done=%b state=%b want 55/1/01", bus.acc, bus.done, bus.state); end
      tick();
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL pwr_len0_pulse: got %b want 0", bus.done); end
   endtask

   task automatic test_reset_mid_run();
      do_load(ADD, 8'h20, 4'd3);
      beat(8'h01);
      checks++; if (bus.acc !== 8'h21 || bus.state !== S_RUN) begin failures++; $display("FAIL mid_pre: acc=%h state=%b want 21/10", bus.acc, bus.state); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.state !== S_READY || bus.acc !== 8'h00 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst: state=%b acc=%h rdy=%b want 01/00/0", bus.state, bus.acc, bus.in_ready); end
      rst = 1'b0;
      tick();
      do_load(ADD, 8'h01, 4'd1);
      beat(8'h02);
      checks++; if (bus.acc !== 8'h03 || bus.done !== 1'b1 || bus.state !== S_READY) begin failures++; $display("FAIL mid_after: acc=%h done=%b state=%b want 03/1/01", bus.acc, bus.done, bus.state); end
      tick();
   endtask

   initial begin
      rst          = 1'b1;
      bus.on       = 1'b1;
      bus.load     = 1'b0;
      bus.op       = ADD;
      bus.a        = 8'h00;
      bus.len      = 4'd0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      #12;
      test_reset();
      test_normal_run();
      test_ops();
      test_overflow();
      test_back_to_back();
      test_power();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
